// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP add/sub issue controller.
package fp_ctrl_pkg;

    // Register depth of the FP add/sub datapath (width of its clear bus).
    localparam int FADD_STAGES = 3;

    // Field capacities of a shadow-pipe entry; RD_W and $clog2(NUM_REQ) must fit.
    localparam int FP_RD_MAX  = 8;
    localparam int FP_SRC_MAX = 4;

    // One shadow-pipe stage: tracks the op occupying the matching datapath register.
    typedef struct packed {
        logic                  vld;
        logic [FP_RD_MAX-1:0]  rd;
        logic                  fp_wb;
        logic [FP_SRC_MAX-1:0] src;
    } fp_inflight_t;

endpackage

// File: rtl/fp_addsub_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer
// moves past the winner only when a grant is actually issued.
module rr_arbiter
    import fp_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Rotating priority search starting at the pointer.
    always_comb begin
        w_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // One-hot grant, suppressed entirely when issue is blocked.
    always_comb begin
        o_gnt = '0;
        if (i_en && w_found) o_gnt[w_idx] = 1'b1;
    end

    assign o_idx = w_idx;
    assign o_any = i_en & w_found;

    // Pointer advances to the slot after the winner on every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ptr <= '0;
        else if (i_en && w_found)
            r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end

endmodule

// File: rtl/fp_addsub_issue_ctrl.sv
// Issue/stall/flush sequencer sharing the pipelined FP add/sub unit between
// requesters. A shadow pipe mirrors the datapath registers so the result tag
// and hazard info line up with the unit's sum output.
module fp_addsub_issue_ctrl
    import fp_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int STAGES  = FADD_STAGES,
    parameter int RD_W    = 5,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][RD_W-1:0]   req_rd,
    input  logic [NUM_REQ-1:0]             req_fp_wb,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [IDX_W-1:0]               unit_sel,
    output logic                           unit_p_start,
    output logic                           unit_en,
    output logic [STAGES-1:0]              unit_clear,
    input  logic                           flush,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [RD_W-1:0]                res_rd,
    output logic                           res_fp_wb,
    output logic [IDX_W-1:0]               res_src,
    output logic [STAGES-1:0][RD_W-1:0]    inflight_rd,
    output logic [STAGES-1:0]              inflight_vld,
    output logic                           busy,
    output logic [CNT_W-1:0]               issue_cnt,
    output logic [CNT_W-1:0]               flush_cnt
);

    localparam int PC_W = $clog2(STAGES + 1);

    fp_inflight_t       r_pipe [STAGES];
    logic [IDX_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_en;
    logic               w_issue;
    logic [IDX_W-1:0]   w_idx;
    logic [PC_W-1:0]    w_pop;
    logic [CNT_W:0]     w_fsum;

    // The whole unit advances only if the tail slot is empty or being drained.
    assign w_en = ~r_pipe[STAGES-1].vld | res_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (req_valid),
        .i_en  (w_en & ~flush),
        .o_gnt (req_ready),
        .o_idx (w_idx),
        .o_any (w_issue)
    );

    assign unit_en      = w_en;
    assign unit_clear   = {STAGES{flush}};
    assign unit_p_start = w_issue;
    assign unit_sel     = r_sel;
    assign res_valid    = r_pipe[STAGES-1].vld;
    assign res_rd       = RD_W'(r_pipe[STAGES-1].rd);
    assign res_fp_wb    = r_pipe[STAGES-1].fp_wb;
    assign res_src      = IDX_W'(r_pipe[STAGES-1].src);
    assign busy         = |inflight_vld;
    assign issue_cnt    = r_issue_cnt;
    assign flush_cnt    = r_flush_cnt;

    // Per-stage hazard view; invalid stages report rd 0.
    always_comb begin
        inflight_vld = '0;
        inflight_rd  = '0;
        for (int k = 0; k < STAGES; k++) begin
            inflight_vld[k] = r_pipe[k].vld;
            inflight_rd[k]  = r_pipe[k].vld ? RD_W'(r_pipe[k].rd) : '0;
        end
    end

    // Number of live ops a flush would discard.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < STAGES; k++) w_pop = w_pop + PC_W'(r_pipe[k].vld);
    end

    assign w_fsum = {1'b0, r_flush_cnt} + (CNT_W + 1)'(w_pop);

    // Shadow pipe: flush wipes it even while stalled; otherwise shift on enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) r_pipe[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) r_pipe[k] <= '0;
        end else if (w_en) begin
            r_pipe[0].vld   <= w_issue;
            r_pipe[0].rd    <= w_issue ? FP_RD_MAX'(req_rd[w_idx]) : '0;
            r_pipe[0].fp_wb <= w_issue ? req_fp_wb[w_idx] : 1'b0;
            r_pipe[0].src   <= w_issue ? FP_SRC_MAX'(w_idx) : '0;
            for (int k = 1; k < STAGES; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    // Operand-mux select follows the latest grant and holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_sel <= '0;
        else if (w_issue) r_sel <= w_idx;
    end

    // Saturating issue and flush statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_issue && r_issue_cnt != '1) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (flush) r_flush_cnt <= w_fsum[CNT_W] ? '1 : w_fsum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_fp_addsub_issue_ctrl.sv
// Directed bench with a result scoreboard for fp_addsub_issue_ctrl.
module tb_fp_addsub_issue_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0][4:0]  req_rd;
    logic [1:0]       req_fp_wb;
    logic [1:0]       req_ready;
    logic [0:0]       unit_sel;
    logic             unit_p_start;
    logic             unit_en;
    logic [2:0]       unit_clear;
    logic             flush;
    logic             res_valid;
    logic             res_ready;
    logic [4:0]       res_rd;
    logic             res_fp_wb;
    logic [0:0]       res_src;
    logic [2:0][4:0]  inflight_rd;
    logic [2:0]       inflight_vld;
    logic             busy;
    logic [15:0]      issue_cnt;
    logic [15:0]      flush_cnt;

    typedef struct packed {
        logic [4:0] rd;
        logic       fp;
        logic       src;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    fp_addsub_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_fp_wb(req_fp_wb), .req_ready(req_ready),
        .unit_sel(unit_sel), .unit_p_start(unit_p_start), .unit_en(unit_en), .unit_clear(unit_clear),
        .flush(flush), .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
        .res_fp_wb(res_fp_wb), .res_src(res_src), .inflight_rd(inflight_rd),
        .inflight_vld(inflight_vld), .busy(busy), .issue_cnt(issue_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Monitor: every accepted result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && res_valid && res_ready && !flush) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_extra: got result rd=%0d src=%0d expected none", res_rd, res_src);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_rd",    32'(res_rd),    32'(e.rd));
                chk("res_fp_wb", 32'(res_fp_wb), 32'(e.fp));
                chk("res_src",   32'(res_src),   32'(e.src));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][4:0] e_ifl;
        rst = 1'b0; req_valid = '0; req_rd = '0; req_fp_wb = '0; flush = 1'b0; res_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_en",     32'(unit_en),      1);
        chk("rst_ready",  32'(req_ready),    0);
        chk("rst_rvalid", 32'(res_valid),    0);
        chk("rst_busy",   32'(busy),         0);
        chk("rst_icnt",   32'(issue_cnt),    0);
        chk("rst_fcnt",   32'(flush_cnt),    0);
        chk("rst_sel",    32'(unit_sel),     0);
        chk("rst_ivld",   32'(inflight_vld), 0);
        step();
        rst = 1'b1;

        // 1: single op, 3-cycle latency
        req_valid = 2'b01; req_rd[0] = 5'd7; req_fp_wb = 2'b01;
        sb.push_back('{rd: 5'd7, fp: 1'b1, src: 1'b0});
        @(negedge clk);
        chk("t1_ready",  32'(req_ready),    2'b01);
        chk("t1_pstart", 32'(unit_p_start), 1);
        step(); req_valid = '0;
        @(negedge clk); chk("t1_lat1", 32'(res_valid), 0); step();
        @(negedge clk); chk("t1_lat2", 32'(res_valid), 0); step();
        @(negedge clk); chk("t1_lat3", 32'(res_valid), 1);
        chk("t1_icnt", 32'(issue_cnt), 1);
        step();

        // 2: both requesting; pointer sits at 1 after test 1, so order is 1,0,1,0,1,0
        req_valid = 2'b11; req_rd[0] = 5'd10; req_rd[1] = 5'd20; req_fp_wb = 2'b10;
        for (int k = 0; k < 6; k++)
            sb.push_back((k % 2 == 0) ? exp_t'({5'd20, 1'b1, 1'b1}) : exp_t'({5'd10, 1'b0, 1'b0}));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t2_gnt", 32'(req_ready), (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k >= 3) chk("t2_b2b", 32'(res_valid), 1);
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t2_tail", 32'(res_valid), 1); step();
        end
        @(negedge clk); chk("t2_drain", 32'(res_valid), 0);
        chk("t2_icnt", 32'(issue_cnt), 7);
        step();

        // 3: fill pipe with writeback stalled, then release
        res_ready = 1'b0; req_valid = 2'b01; req_fp_wb = 2'b00;
        for (int k = 0; k < 3; k++) begin
            req_rd[0] = 5'(k + 1);
            sb.push_back('{rd: 5'(k + 1), fp: 1'b0, src: 1'b0});
            @(negedge clk); chk("t3_fill", 32'(req_ready), 2'b01);
            step();
        end
        req_rd[0] = 5'd4;
        sb.push_back('{rd: 5'd4, fp: 1'b0, src: 1'b0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_en",    32'(unit_en),   0);
            chk("t3_ready", 32'(req_ready), 0);
            chk("t3_hold",  32'(res_rd),    1);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume_en",    32'(unit_en),   1);
        chk("t3_resume_ready", 32'(req_ready), 2'b01);
        step(); req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t3_stream", 32'(res_valid), 1); step();
        end
        @(negedge clk); chk("t3_drain", 32'(res_valid), 0);
        chk("t3_icnt", 32'(issue_cnt), 11);
        step();

        // 4: three ops in flight, one-cycle flush (result at tail is dropped despite res_ready)
        req_valid = 2'b10; req_fp_wb = 2'b10;
        for (int k = 0; k < 3; k++) begin
            req_rd[1] = 5'(9 + k);
            if (k == 2) begin
                @(negedge clk);
                e_ifl = '0; e_ifl[1] = 5'd9; e_ifl[0] = 5'd10;
                chk("t4_ivld", 32'(inflight_vld), 3'b011);
                chk("t4_ird",  32'(inflight_rd),  32'(e_ifl));
            end
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("t4_clear",  32'(unit_clear),   3'b111);
        chk("t4_nogrnt", 32'(req_ready),    0);
        chk("t4_pstart", 32'(unit_p_start), 0);
        chk("t4_busy1",  32'(busy),         1);
        step(); flush = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("t4_busy0", 32'(busy),      0);
        chk("t4_fcnt",  32'(flush_cnt), 3);
        chk("t4_rv",    32'(res_valid), 0);
        chk("t4_icnt",  32'(issue_cnt), 14);
        step();

        // 5: flush while stalled
        res_ready = 1'b0; req_valid = 2'b01; req_fp_wb = 2'b00;
        for (int k = 0; k < 3; k++) begin
            req_rd[0] = 5'(5 + k);
            step();
        end
        req_valid = '0;
        @(negedge clk);
        chk("t5_stall_rv", 32'(res_valid), 1);
        chk("t5_stall_en", 32'(unit_en),   0);
        step(); flush = 1'b1;
        @(negedge clk);
        chk("t5_clear", 32'(unit_clear), 3'b111);
        step(); flush = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(busy),      0);
        chk("t5_fcnt", 32'(flush_cnt), 6);
        for (int k = 0; k < 3; k++) begin
            step(); @(negedge clk); chk("t5_quiet", 32'(res_valid), 0);
        end
        step();

        // 6: reset mid-stream
        req_valid = 2'b11; req_rd[0] = 5'd12; req_rd[1] = 5'd13; req_fp_wb = 2'b01;
        step(); step();
        rst = 1'b0; req_valid = '0;
        #1;
        chk("t6_busy",   32'(busy),         0);
        chk("t6_rv",     32'(res_valid),    0);
        chk("t6_en",     32'(unit_en),      1);
        chk("t6_icnt",   32'(issue_cnt),    0);
        chk("t6_fcnt",   32'(flush_cnt),    0);
        chk("t6_ready",  32'(req_ready),    0);
        chk("t6_pstart", 32'(unit_p_start), 0);
        step();
        rst = 1'b1; req_valid = 2'b11;
        sb.push_back('{rd: 5'd12, fp: 1'b1, src: 1'b0});
        @(negedge clk); chk("t6_first_gnt", 32'(req_ready), 2'b01);
        step(); req_valid = '0;
        repeat (5) step();
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("t6_icnt_end", 32'(issue_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
